nn_core: RTL and testbench

// - Fixed-weight 2-input neural-network forward-pass engine (2 hidden neurons, 1 output neuron).
// - After reset, loads 16 constants from an internal ROM into a register file.
// - Then runs a 5-cycle pipelined FSM per enable pulse.
// - Reports the result plus sticky overflow/zero flags and the first stage that raised each.

---
 rtl/nn_core.sv | 261 ++++++++++++++++++++++++++
 tb/tb_nn_core.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/nn_core.sv
// nn_core: fixed-weight 2-2-1 neural-network forward pass with saturating arithmetic.
// Weights are copied from a 16-word ROM into a register file after every reset.
module nn_core #(
  parameter int DATAWIDTH = 32
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        enable,
  input  logic signed [DATAWIDTH-1:0] input_1,
  input  logic signed [DATAWIDTH-1:0] input_2,
  output logic signed [DATAWIDTH-1:0] final_output,
  output logic                        total_ovf,
  output logic                        total_zero,
  output logic [2:0]                  ovf_fsm_stage,
  output logic [2:0]                  zero_fsm_stage
);
  localparam int W = DATAWIDTH;
  localparam logic signed [W-1:0]   SAT_MAX  = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0]   SAT_MIN  = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [2*W-1:0] WIDE_MAX = {{(W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [2*W-1:0] WIDE_MIN = {{(W+1){1'b1}}, {(W-1){1'b0}}};

  localparam logic [2:0] STG_NONE  = 3'd0;
  localparam logic [2:0] STG_PRE   = 3'd1;
  localparam logic [2:0] STG_INPUT = 3'd2;
  localparam logic [2:0] STG_OUT   = 3'd3;
  localparam logic [2:0] STG_POST  = 3'd4;

  typedef enum logic [2:0] {
    S_LOAD, S_IDLE, S_PRE, S_INPUT, S_OUT1, S_OUT2, S_POST
  } state_t;

  typedef struct packed {
    logic                ovf;
    logic signed [W-1:0] val;
  } sat_t;

  function automatic logic signed [2*W-1:0] sext(input logic signed [W-1:0] a);
    return {{W{a[W-1]}}, a};
  endfunction

  function automatic sat_t sat_wide(input logic signed [2*W-1:0] v);
    sat_t r;
    if (v > WIDE_MAX) begin
      r.ovf = 1'b1;
      r.val = SAT_MAX;
    end else if (v < WIDE_MIN) begin
      r.ovf = 1'b1;
      r.val = SAT_MIN;
    end else begin
      r.ovf = 1'b0;
      r.val = v[W-1:0];
    end
    return r;
  endfunction

  // Operands are widened to 2*W so the exact result is always representable.
  function automatic sat_t mul_sat(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
    return sat_wide(sext(a) * sext(b));
  endfunction

  function automatic sat_t add_sat(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
    return sat_wide(sext(a) + sext(b));
  endfunction

  function automatic sat_t shl_sat(input logic signed [W-1:0] a, input logic [4:0] sh);
    return sat_wide(sext(a) <<< sh);
  endfunction

  function automatic logic signed [W-1:0] rom_word(input logic [3:0] addr);
    logic signed [W-1:0] r;
    case (addr)
      4'd0:    r = W'(1);
      4'd1:    r = W'(1);
      4'd2:    r = W'(2);
      4'd3:    r = W'(3);
      4'd4:    r = W'(4);
      4'd5:    r = W'(5);
      4'd6:    r = W'(1);
      4'd7:    r = W'(2);
      4'd8:    r = W'(9);
      4'd9:    r = W'(1);
      default: r = '0;
    endcase
    return r;
  endfunction

  state_t              state_q, state_d;
  logic [3:0]          load_cnt_q, load_cnt_d;
  logic [3:0]          cnt_m1;
  logic signed [W-1:0] rf_q [16];
  logic signed [W-1:0] rf_d [16];
  logic [2:0]          ovf_stg_q, ovf_stg_d, zero_stg_q, zero_stg_d;
  logic signed [W-1:0] final_output_q, final_output_d;
  logic                total_ovf_q, total_ovf_d, total_zero_q, total_zero_d;
  logic [2:0]          ovf_fsm_stage_q, ovf_fsm_stage_d;
  logic [2:0]          zero_fsm_stage_q, zero_fsm_stage_d;

  logic signed [W-1:0] rom_rd0_q, rom_rd0_d, rom_rd1_q, rom_rd1_d;
  logic signed [W-1:0] in1_p0_q, in1_p0_d, in2_p0_q, in2_p0_d;
  logic signed [W-1:0] x1_p1_q, x1_p1_d, x2_p1_q, x2_p1_d;
  logic signed [W-1:0] n1_p2_q, n1_p2_d, n2_p2_q, n2_p2_d;
  logic signed [W-1:0] p1_p3_q, p1_p3_d, p2_p3_q, p2_p3_d;
  logic signed [W-1:0] o_p4_q, o_p4_d;

  logic signed [W-1:0] x1_w, x2_w;
  sat_t                m1, a1, m2, a2, q1, q2, s_sum, o_sum, f_sh;

  always_comb begin
    x1_w  = in1_p0_q >>> rf_q[0][4:0];
    x2_w  = in2_p0_q >>> rf_q[1][4:0];
    m1    = mul_sat(x1_p1_q, rf_q[2]);
    a1    = add_sat(m1.val, rf_q[3]);
    m2    = mul_sat(x2_p1_q, rf_q[4]);
    a2    = add_sat(m2.val, rf_q[5]);
    q1    = mul_sat(n1_p2_q, rf_q[6]);
    q2    = mul_sat(n2_p2_q, rf_q[7]);
    s_sum = add_sat(p1_p3_q, p2_p3_q);
    o_sum = add_sat(s_sum.val, rf_q[8]);
    f_sh  = shl_sat(o_p4_q, rf_q[9][4:0]);
  end

  always_comb begin
    state_d          = state_q;
    load_cnt_d       = load_cnt_q;
    cnt_m1           = load_cnt_q - 4'd1;
    rf_d             = rf_q;
    ovf_stg_d        = ovf_stg_q;
    zero_stg_d       = zero_stg_q;
    final_output_d   = final_output_q;
    total_ovf_d      = total_ovf_q;
    total_zero_d     = total_zero_q;
    ovf_fsm_stage_d  = ovf_fsm_stage_q;
    zero_fsm_stage_d = zero_fsm_stage_q;
    rom_rd0_d        = rom_rd0_q;
    rom_rd1_d        = rom_rd1_q;
    in1_p0_d         = in1_p0_q;
    in2_p0_d         = in2_p0_q;
    x1_p1_d          = x1_p1_q;
    x2_p1_d          = x2_p1_q;
    n1_p2_d          = n1_p2_q;
    n2_p2_d          = n2_p2_q;
    p1_p3_d          = p1_p3_q;
    p2_p3_d          = p2_p3_q;
    o_p4_d           = o_p4_q;
    case (state_q)
      // ROM read of pair k lands one cycle before it is written into the file
      S_LOAD: begin
        load_cnt_d = load_cnt_q + 4'd1;
        if (!load_cnt_q[3]) begin
          rom_rd0_d = rom_word({load_cnt_q[2:0], 1'b0});
          rom_rd1_d = rom_word({load_cnt_q[2:0], 1'b1});
        end
        if (load_cnt_q != 4'd0) begin
          rf_d[{cnt_m1[2:0], 1'b0}] = rom_rd0_q;
          rf_d[{cnt_m1[2:0], 1'b1}] = rom_rd1_q;
        end
        if (load_cnt_q == 4'd8) begin
          state_d    = S_IDLE;
          load_cnt_d = 4'd0;
        end
      end
      S_IDLE: begin
        if (enable) begin
          state_d    = S_PRE;
          in1_p0_d   = input_1;
          in2_p0_d   = input_2;
          ovf_stg_d  = STG_NONE;
          zero_stg_d = STG_NONE;
        end
      end
      // p0 -> p1: input scaling
      S_PRE: begin
        state_d = S_INPUT;
        x1_p1_d = x1_w;
        x2_p1_d = x2_w;
        if (zero_stg_q == STG_NONE && (x1_w == '0 || x2_w == '0)) zero_stg_d = STG_PRE;
      end
      // p1 -> p2: hidden neurons
      S_INPUT: begin
        state_d = S_OUT1;
        n1_p2_d = a1.val;
        n2_p2_d = a2.val;
        if (ovf_stg_q == STG_NONE && (m1.ovf || a1.ovf || m2.ovf || a2.ovf))
          ovf_stg_d = STG_INPUT;
        if (zero_stg_q == STG_NONE && (a1.val == '0 || a2.val == '0)) zero_stg_d = STG_INPUT;
      end
      // p2 -> p3: output weights
      S_OUT1: begin
        state_d = S_OUT2;
        p1_p3_d = q1.val;
        p2_p3_d = q2.val;
        if (ovf_stg_q == STG_NONE && (q1.ovf || q2.ovf)) ovf_stg_d = STG_OUT;
        if (zero_stg_q == STG_NONE && (q1.val == '0 || q2.val == '0)) zero_stg_d = STG_OUT;
      end
      // p3 -> p4: output sum and bias
      S_OUT2: begin
        state_d = S_POST;
        o_p4_d  = o_sum.val;
        if (ovf_stg_q == STG_NONE && (s_sum.ovf || o_sum.ovf)) ovf_stg_d = STG_OUT;
        if (zero_stg_q == STG_NONE && o_sum.val == '0) zero_stg_d = STG_OUT;
      end
      // p4 -> output: final scaling, publish result and flags together
      S_POST: begin
        state_d          = S_IDLE;
        final_output_d   = f_sh.val;
        ovf_fsm_stage_d  = (ovf_stg_q == STG_NONE && f_sh.ovf) ? STG_POST : ovf_stg_q;
        zero_fsm_stage_d = (zero_stg_q == STG_NONE && f_sh.val == '0) ? STG_POST : zero_stg_q;
        total_ovf_d      = (ovf_fsm_stage_d != STG_NONE);
        total_zero_d     = (f_sh.val == '0);
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state_q          <= S_LOAD;
      load_cnt_q       <= 4'd0;
      for (int i = 0; i < 16; i++) rf_q[i] <= '0;
      ovf_stg_q        <= STG_NONE;
      zero_stg_q       <= STG_NONE;
      final_output_q   <= '0;
      total_ovf_q      <= 1'b0;
      total_zero_q     <= 1'b0;
      ovf_fsm_stage_q  <= STG_NONE;
      zero_fsm_stage_q <= STG_NONE;
    end else begin
      state_q          <= state_d;
      load_cnt_q       <= load_cnt_d;
      rf_q             <= rf_d;
      ovf_stg_q        <= ovf_stg_d;
      zero_stg_q       <= zero_stg_d;
      final_output_q   <= final_output_d;
      total_ovf_q      <= total_ovf_d;
      total_zero_q     <= total_zero_d;
      ovf_fsm_stage_q  <= ovf_fsm_stage_d;
      zero_fsm_stage_q <= zero_fsm_stage_d;
    end
  end

  always_ff @(posedge clk) begin
    rom_rd0_q <= rom_rd0_d;
    rom_rd1_q <= rom_rd1_d;
    in1_p0_q  <= in1_p0_d;
    in2_p0_q  <= in2_p0_d;
    x1_p1_q   <= x1_p1_d;
    x2_p1_q   <= x2_p1_d;
    n1_p2_q   <= n1_p2_d;
    n2_p2_q   <= n2_p2_d;
    p1_p3_q   <= p1_p3_d;
    p2_p3_q   <= p2_p3_d;
    o_p4_q    <= o_p4_d;
  end

  assign final_output   = final_output_q;
  assign total_ovf      = total_ovf_q;
  assign total_zero     = total_zero_q;
  assign ovf_fsm_stage  = ovf_fsm_stage_q;
  assign zero_fsm_stage = zero_fsm_stage_q;
endmodule

// File: tb/tb_nn_core.sv
// Directed bench for nn_core: vector table for single passes plus hand-written
// sequences for reset-during-LOAD, back-to-back enables and reset mid-pass.
`timescale 1ns/1ps
module tb_nn_core;
  logic               clk = 1'b0;
  logic               resetn;
  logic               enable;
  logic signed [31:0] input_1, input_2;
  logic signed [31:0] final_output;
  logic               total_ovf, total_zero;
  logic [2:0]         ovf_fsm_stage, zero_fsm_stage;

  always #5 clk = ~clk;

  nn_core #(.DATAWIDTH(32)) dut (
    .clk(clk), .resetn(resetn), .enable(enable),
    .input_1(input_1), .input_2(input_2),
    .final_output(final_output), .total_ovf(total_ovf), .total_zero(total_zero),
    .ovf_fsm_stage(ovf_fsm_stage), .zero_fsm_stage(zero_fsm_stage)
  );

  typedef struct {
    logic signed [31:0] in1;
    logic signed [31:0] in2;
    logic signed [31:0] out;
    logic               ovf;
    logic               zero;
    logic [2:0]         os;
    logic [2:0]         zs;
  } vec_t;

  vec_t vecs [7];
  int   n_vec  = 0;
  int   n_miss = 0;
  logic [31:0] prev;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] o, input logic ov,
                         input logic z, input logic [2:0] os, input logic [2:0] zs);
    chk({tag, " final_output"}, final_output, o);
    chk({tag, " total_ovf"}, {31'b0, total_ovf}, {31'b0, ov});
    chk({tag, " total_zero"}, {31'b0, total_zero}, {31'b0, z});
    chk({tag, " ovf_fsm_stage"}, {29'b0, ovf_fsm_stage}, {29'b0, os});
    chk({tag, " zero_fsm_stage"}, {29'b0, zero_fsm_stage}, {29'b0, zs});
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    vecs[0] = '{32'sd100,         32'sd50, 32'sd644,        1'b0, 1'b0, 3'd0, 3'd0};
    vecs[1] = '{-32'sd22,         32'sd0,  32'sd0,          1'b0, 1'b1, 3'd0, 3'd1};
    vecs[2] = '{32'sd10,          -32'sd6, 32'sd16,         1'b0, 1'b0, 3'd0, 3'd0};
    vecs[3] = '{32'sh7FFF_FFFF,   32'sd50, 32'sh7FFF_FFFF,  1'b1, 1'b0, 3'd2, 3'd0};
    vecs[4] = '{-32'sd1,          -32'sd1, 32'sd24,         1'b0, 1'b0, 3'd0, 3'd0};
    vecs[5] = '{32'sh8000_0000,   32'sd50, 32'sh8000_0000,  1'b1, 1'b0, 3'd4, 3'd0};
    vecs[6] = '{-32'sd30,         32'sd2,  32'sd0,          1'b0, 1'b1, 3'd0, 3'd3};

    resetn  = 1'b1;
    enable  = 1'b0;
    input_1 = 32'sd100;
    input_2 = 32'sd50;
    step(2);
    resetn = 1'b0;
    enable = 1'b1;
    step(8);
    enable = 1'b0;
    step(2);
    chk_all("after_reset", 32'd0, 1'b0, 1'b0, 3'd0, 3'd0);

    prev = 32'd0;
    for (int i = 0; i < 7; i++) begin
      input_1 = vecs[i].in1;
      input_2 = vecs[i].in2;
      enable  = 1'b1;
      step(1);
      enable  = 1'b0;
      input_1 = 32'sd12345;
      input_2 = -32'sd777;
      step(4);
      chk($sformatf("vec%0d hold", i), final_output, prev);
      step(1);
      chk_all($sformatf("vec%0d", i), vecs[i].out, vecs[i].ovf, vecs[i].zero,
              vecs[i].os, vecs[i].zs);
      prev = vecs[i].out;
    end

    input_1 = 32'sd100;
    input_2 = 32'sd50;
    enable  = 1'b1;
    step(6);
    chk("b2b first", final_output, 32'd644);
    input_1 = -32'sd1;
    input_2 = -32'sd1;
    step(1);
    input_1 = 32'sd10;
    input_2 = -32'sd6;
    step(1);
    enable = 1'b0;
    step(3);
    chk("b2b second hold", final_output, 32'd644);
    step(1);
    chk_all("b2b second", 32'd24, 1'b0, 1'b0, 3'd0, 3'd0);
    step(8);
    chk("b2b no extra pass", final_output, 32'd24);

    input_1 = 32'sd100;
    input_2 = 32'sd50;
    enable  = 1'b1;
    step(1);
    enable = 1'b0;
    step(2);
    resetn = 1'b1;
    #1;
    chk_all("reset_in_out1", 32'd0, 1'b0, 1'b0, 3'd0, 3'd0);
    step(1);
    resetn = 1'b0;
    step(9);
    enable = 1'b1;
    step(1);
    enable = 1'b0;
    step(4);
    chk("post_reset hold", final_output, 32'd0);
    step(1);
    chk_all("post_reset pass", 32'd644, 1'b0, 1'b0, 3'd0, 3'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
